// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared definitions for the modular add/subtract sequencer: state encodings,
// operation codes and the default operand width.
package mod_addsub_ctrl_pkg;

    localparam int unsigned N_DEF = 512;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_W1   = 3'd2,
        ST_S2   = 3'd3,
        ST_W2   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Drives the shared multi-precision adder twice per request (raw op, then a
// correction by m) to produce r = (a +/- b) mod m.
module mod_addsub_ctrl
    import mod_addsub_ctrl_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           op_sub,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [N-1:0]   in_m,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic           adder_start,
    output logic           adder_subtract,
    output logic [N:0]     adder_in_a,
    output logic [N:0]     adder_in_b,
    input  logic [N+1:0]   adder_result,
    input  logic           adder_done
);

    localparam int unsigned AW = N + 1;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic           op_q, op_d;
    logic           r1_neg_q, r1_neg_d;
    logic [N-1:0]   r1_lo_q, r1_lo_d;
    logic           guard_q, guard_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   result_q, result_d;
    logic           ast_q, ast_d;
    logic           asub_q, asub_d;
    logic [AW-1:0]  ain_q, ain_d;
    logic [AW-1:0]  bin_q, bin_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            op_q     <= 1'b0;
            r1_neg_q <= 1'b0;
            r1_lo_q  <= '0;
            guard_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ast_q    <= 1'b0;
            asub_q   <= 1'b0;
            ain_q    <= '0;
            bin_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            op_q     <= op_d;
            r1_neg_q <= r1_neg_d;
            r1_lo_q  <= r1_lo_d;
            guard_q  <= guard_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ast_q    <= ast_d;
            asub_q   <= asub_d;
            ain_q    <= ain_d;
            bin_q    <= bin_d;
        end
    end

    // Next-state and next-output logic. Adder controls are set on the
    // transition into S1/S2 so they appear registered during those states.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        op_d     = op_q;
        r1_neg_d = r1_neg_q;
        r1_lo_d  = r1_lo_q;
        guard_d  = guard_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ast_d    = 1'b0;
        asub_d   = asub_q;
        ain_d    = ain_q;
        bin_d    = bin_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = in_m;
                    op_d    = op_sub;
                    busy_d  = 1'b1;
                    ast_d   = 1'b1;
                    asub_d  = op_sub;
                    ain_d   = AW'(in_a);
                    bin_d   = AW'(in_b);
                    state_d = ST_S1;
                end
            end
            ST_S1: begin
                guard_d = 1'b1;
                state_d = ST_W1;
            end
            ST_W1: begin
                // The first W1 cycle ignores adder_done so a stale level is never taken.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (adder_done) begin
                    r1_neg_d = adder_result[N+1];
                    r1_lo_d  = adder_result[N-1:0];
                    ast_d    = 1'b1;
                    asub_d   = (op_q == OP_ADD);
                    ain_d    = adder_result[N:0];
                    bin_d    = AW'(m_q);
                    state_d  = ST_S2;
                end
            end
            ST_S2: begin
                guard_d = 1'b1;
                state_d = ST_W2;
            end
            ST_W2: begin
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (adder_done) begin
                    if (op_q == OP_ADD) begin
                        result_d = adder_result[N+1] ? r1_lo_q : adder_result[N-1:0];
                    end else begin
                        result_d = r1_neg_q ? adder_result[N-1:0] : r1_lo_q;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign adder_start    = ast_q;
    assign adder_subtract = asub_q;
    assign adder_in_a     = ain_q;
    assign adder_in_b     = bin_q;

endmodule
